// File: rtl/joy_serial_scan.sv
// Serial scanner for a chain of 74HC165-style controller shift registers.
// Produces debounced active-high button words, presence flags and change strobes per player.
module joy_serial_scan #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 50,
  parameter int SCAN_GAP        = 1000,
  parameter int DEBOUNCE        = 2
) (
  input  logic                                   clk,
  input  logic                                   Reset_n,
  input  logic                                   enable,
  input  logic                                   JOY_DATA,
  output logic                                   JOY_CLK,
  output logic                                   JOY_LOAD,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic [NUM_PLAYERS-1:0]                 present,
  output logic [NUM_PLAYERS-1:0]                 changed,
  output logic                                   scan_done
);

  localparam int B     = BITS_PER_PLAYER;
  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int GW    = $clog2(SCAN_GAP + 1);
  localparam int IW    = $clog2(TOTAL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_div;
  logic              w_tick;
  logic [GW-1:0]     r_gap;
  logic [IW-1:0]     r_idx;
  logic [TOTAL-1:0]  r_shift;
  logic [1:0]        r_sync;
  logic              r_joy_clk;
  logic              r_joy_load;
  logic              r_scan_done;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && (r_gap == GW'(SCAN_GAP)) && enable) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_tick) begin
          w_state_next = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (w_tick) begin
          w_state_next = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (w_tick) begin
          w_state_next = (r_idx == IW'(TOTAL - 1)) ? ST_DONE : ST_SHIFT_LO;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The chain output is asynchronous to clk, so it passes a two-stage synchroniser;
  // it is sampled a full half-period after it last moved, so the delay is harmless.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_sync      <= 2'b11;
      r_gap       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_joy_clk   <= 1'b1;
      r_joy_load  <= 1'b1;
      r_scan_done <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], JOY_DATA};
      if ((r_state == ST_IDLE) && w_tick) begin
        if (w_state_next == ST_LOAD) begin
          r_gap <= '0;
        end else if (r_gap != GW'(SCAN_GAP)) begin
          r_gap <= r_gap + GW'(1);
        end
      end
      if (r_state == ST_LOAD) begin
        r_idx <= '0;
      end else if ((r_state == ST_SHIFT_HI) && w_tick) begin
        r_idx <= r_idx + IW'(1);
      end
      if ((r_state == ST_SHIFT_LO) && w_tick) begin
        r_shift <= {r_shift[TOTAL-2:0], ~r_sync[1]};
      end
      // Pins follow the next state so they change on the same edge as the FSM.
      r_joy_clk   <= (w_state_next != ST_SHIFT_LO);
      r_joy_load  <= (w_state_next != ST_LOAD);
      r_scan_done <= (r_state == ST_DONE);
    end
  end

  assign JOY_CLK   = r_joy_clk;
  assign JOY_LOAD  = r_joy_load;
  assign scan_done = r_scan_done;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [B-1:0] w_raw;
      logic [B-1:0] w_cand_next;
      logic [3:0]   w_cnt_next;
      logic         w_take;
      logic         w_absent;
      logic [B-1:0] r_cand;
      logic [B-1:0] r_joy;
      logic [3:0]   r_cnt;
      logic         r_present;
      logic         r_changed;

      // Player 0 was shifted in first, so it ends up in the top slice.
      assign w_raw    = r_shift[(NUM_PLAYERS-1-gi)*B +: B];
      assign w_absent = &w_raw;

      always_comb begin
        w_cand_next = w_raw;
        w_cnt_next  = 4'd1;
        if (w_raw == r_cand) begin
          w_cand_next = r_cand;
          w_cnt_next  = (r_cnt >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : r_cnt + 4'd1;
        end
        w_take = (w_cnt_next >= 4'(DEBOUNCE)) && (w_cand_next != r_joy);
      end

      always_ff @(posedge clk) begin
        if (!Reset_n) begin
          r_cand    <= '0;
          r_joy     <= '0;
          r_cnt     <= '0;
          r_present <= 1'b0;
          r_changed <= 1'b0;
        end else begin
          r_changed <= 1'b0;
          if (r_state == ST_DONE) begin
            if (w_absent) begin
              r_present <= 1'b0;
              r_joy     <= '0;
              r_cand    <= '0;
              r_cnt     <= '0;
              r_changed <= |r_joy;
            end else begin
              r_present <= 1'b1;
              r_cand    <= w_cand_next;
              r_cnt     <= w_cnt_next;
              if (w_take) begin
                r_joy     <= w_cand_next;
                r_changed <= 1'b1;
              end
            end
          end
        end
      end

      assign joystick[gi*B +: B] = r_joy;
      assign present[gi]         = r_present;
      assign changed[gi]         = r_changed;
    end
  endgenerate

endmodule

// File: tb/tb_joy_serial_scan.sv
// Bench for joy_serial_scan: a 74HC165 chain model feeds directed button patterns;
// a scoreboard queue holds the expected result of each scan and a monitor checks it at scan_done.
module tb_joy_serial_scan;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [23:0] joystick;
  logic [1:0]  present;
  logic [1:0]  changed;
  logic        scan_done;

  logic [11:0] vec_p0;
  logic [11:0] vec_p1;
  logic [23:0] chain = '1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] joy;
    logic [1:0]  pres;
    logic [1:0]  chg;
  } exp_t;

  exp_t sb[$];

  joy_serial_scan #(
    .NUM_PLAYERS(2),
    .BITS_PER_PLAYER(12),
    .CLK_DIV(4),
    .SCAN_GAP(2),
    .DEBOUNCE(2)
  ) dut (
    .clk(clk),
    .Reset_n(Reset_n),
    .enable(enable),
    .JOY_DATA(JOY_DATA),
    .JOY_CLK(JOY_CLK),
    .JOY_LOAD(JOY_LOAD),
    .joystick(joystick),
    .present(present),
    .changed(changed),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Chain model: parallel load of active-low buttons, P0 MSB leaves first.
  assign JOY_DATA = chain[23];
  always @(negedge JOY_LOAD) chain <= ~{vec_p0, vec_p1};
  always @(posedge JOY_CLK) if (JOY_LOAD) chain <= {chain[22:0], 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every scan_done pops one expectation.
  always @(negedge clk) begin
    if (Reset_n === 1'b1 && scan_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_scan: got scan_done expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("scan_joystick", 32'(joystick), 32'(e.joy));
        chk("scan_present", 32'(present), 32'(e.pres));
        chk("scan_changed", 32'(changed), 32'(e.chg));
      end
    end else if (Reset_n === 1'b1 && changed !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL stray_changed: got %0h expected 0 outside scan_done", changed);
    end
  end

  task automatic push_exp(input logic [23:0] j, input logic [1:0] p, input logic [1:0] c);
    exp_t e;
    e.joy  = j;
    e.pres = p;
    e.chg  = c;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (scan_done) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no scan_done expected a pulse within 400 clk", name);
    end
  endtask

  task automatic run_scan(input string name, input logic [11:0] a0, input logic [11:0] a1,
                          input logic [23:0] ej, input logic [1:0] ep, input logic [1:0] ec);
    vec_p0 = a0;
    vec_p1 = a1;
    push_exp(ej, ep, ec);
    wait_done(name);
  endtask

  task automatic wait_load_low(output bit got, output int delay);
    got   = 0;
    delay = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      delay++;
      if (!JOY_LOAD) got = 1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_joy_clk"}, 32'(JOY_CLK), 32'd1);
    chk({tag, "_joy_load"}, 32'(JOY_LOAD), 32'd1);
    chk({tag, "_joystick"}, 32'(joystick), 32'd0);
    chk({tag, "_present"}, 32'(present), 32'd0);
    chk({tag, "_changed"}, 32'(changed), 32'd0);
    chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
  endtask

  initial begin
    bit got;
    int delay;
    int load_lows;
    int t_done;
    int bad;
    int n;
    int rises;
    logic prev_clk;
    int fall_t[$];
    int rise_t[$];

    Reset_n = 1'b0;
    enable  = 1'b0;
    vec_p0  = '0;
    vec_p1  = '0;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");

    // Disabled: the chain must never be loaded.
    Reset_n   = 1'b1;
    load_lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!JOY_LOAD) load_lows++;
    end
    chk("idle_no_load", 32'(load_lows), 32'd0);

    // Scan 1 with waveform timing; first sighting of data only loads the candidate.
    vec_p0 = 12'h008;
    vec_p1 = 12'h011;
    push_exp(24'h0, 2'b11, 2'b00);
    enable = 1'b1;
    wait_load_low(got, delay);
    chk("load_seen", 32'(got), 32'd1);
    load_lows = 1;
    t_done    = -1;
    prev_clk  = JOY_CLK;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!JOY_LOAD) load_lows++;
      if (prev_clk && !JOY_CLK) fall_t.push_back(k + 1);
      if (!prev_clk && JOY_CLK) rise_t.push_back(k + 1);
      prev_clk = JOY_CLK;
      if (scan_done && t_done < 0) t_done = k + 1;
    end
    chk("load_low_clks", 32'(load_lows), 32'd4);
    chk("clk_falls", 32'(fall_t.size()), 32'd24);
    chk("clk_rises", 32'(rise_t.size()), 32'd24);
    if (fall_t.size() > 0) chk("first_fall_offset", 32'(fall_t[0]), 32'd4);
    bad = 0;
    n = (fall_t.size() < rise_t.size()) ? fall_t.size() : rise_t.size();
    for (int i = 0; i < n; i++) begin
      if (rise_t[i] - fall_t[i] != 4) bad++;
      if (i + 1 < fall_t.size() && fall_t[i+1] - rise_t[i] != 4) bad++;
    end
    chk("clk_phase_widths_bad", 32'(bad), 32'd0);
    chk("scan_done_offset", 32'(t_done), 32'd197);

    // Scan 2: second identical scan updates both players.
    run_scan("scan2", 12'h008, 12'h011, {12'h011, 12'h008}, 2'b11, 2'b11);

    // Glitch rejection on P0.
    run_scan("glitch_a", 12'h001, 12'h011, {12'h011, 12'h008}, 2'b11, 2'b00);
    run_scan("glitch_b", 12'h001, 12'h011, {12'h011, 12'h001}, 2'b11, 2'b01);
    run_scan("glitch_c", 12'h002, 12'h011, {12'h011, 12'h001}, 2'b11, 2'b00);
    run_scan("glitch_d", 12'h001, 12'h011, {12'h011, 12'h001}, 2'b11, 2'b00);
    run_scan("glitch_e", 12'h001, 12'h011, {12'h011, 12'h001}, 2'b11, 2'b00);

    // P1 wire held low: absent, slice cleared, one change pulse.
    run_scan("absent_a", 12'h001, 12'hFFF, {12'h000, 12'h001}, 2'b01, 2'b10);
    run_scan("absent_b", 12'h001, 12'hFFF, {12'h000, 12'h001}, 2'b01, 2'b00);
    run_scan("return", 12'h001, 12'h011, {12'h000, 12'h001}, 2'b11, 2'b00);

    // Reset in the middle of a scan carrying new data.
    vec_p0 = 12'h004;
    vec_p1 = 12'h022;
    wait_load_low(got, delay);
    chk("midscan_load_seen", 32'(got), 32'd1);
    rises    = 0;
    prev_clk = JOY_CLK;
    for (int i = 0; i < 400 && rises < 10; i++) begin
      @(negedge clk);
      if (!prev_clk && JOY_CLK) rises++;
      prev_clk = JOY_CLK;
    end
    Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midscan");
    Reset_n = 1'b1;
    push_exp(24'h0, 2'b11, 2'b00);
    wait_load_low(got, delay);
    chk("post_reset_load_seen", 32'(got), 32'd1);
    checks++;
    if (delay < 8 || delay > 16) begin
      errors++;
      $display("FAIL post_reset_gap: got %0d clk expected 8..16", delay);
    end else begin
      $display("ok   post_reset_gap: %0d clk", delay);
    end
    wait_done("post_reset_scan1");
    run_scan("post_reset_scan2", 12'h004, 12'h022, {12'h022, 12'h004}, 2'b11, 2'b11);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joy_serial_scan.md
Name: joy_serial_scan

Overview:
- Parametrised successor to the two-player DB15 SNAC reader.
- Scans N daisy-chained 74HC165-style shift registers over the user port using JOY_LOAD, JOY_CLK and JOY_DATA.
- Converts the active-low wire data to per-player active-high button words, with per-player debounce, presence detection and change strobes.
- Sits between USER_IN/USER_OUT and the emu-level joystick muxing.

Parameters:
- NUM_PLAYERS, 2, number of chained controllers (1..4).
- BITS_PER_PLAYER, 12, bits shifted per controller (4..16).
- CLK_DIV, 50, clk cycles per serial tick (>=2).
- SCAN_GAP, 1000, idle ticks between scans (>=1).
- DEBOUNCE, 2, consecutive identical scans needed before an output word updates (1..15; 1 = immediate).

Ports:
- clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- enable  in  1  scanning permitted; sampled only in IDLE.
- JOY_DATA  in  1  serial data from chain, active-low buttons.
- JOY_CLK  out  1  shift clock to chain.
- JOY_LOAD  out  1  parallel load, active-low.
- joystick  out  NUM_PLAYERS*BITS_PER_PLAYER  debounced active-high words; player p at [p*B +: B].
- present  out  NUM_PLAYERS  controller detected per player.
- changed  out  NUM_PLAYERS  1-cycle pulse when that player's joystick word updates.
- scan_done  out  1  1-cycle pulse at end of every completed scan.

Behaviour:
- Reset values (Reset_n low at a clk edge): JOY_CLK=1, JOY_LOAD=1, joystick=0, present=0, changed=0, scan_done=0. Reset also clears the divider, FSM (to IDLE), gap counter, shift register, candidates and debounce counters. Reset mid-scan aborts immediately; no partial data reaches outputs.
- Tick: divider counts 0..CLK_DIV-1; tick is asserted for one clk when the count equals CLK_DIV-1. All FSM state changes happen on tick except DONE.
- FSM:
  - IDLE: JOY_CLK=1, JOY_LOAD=1. Gap counter increments per tick. When gap reaches SCAN_GAP and enable=1: clear gap, go to LOAD. If enable=0, stay in IDLE with the gap counter saturated.
  - LOAD: JOY_LOAD=0 for exactly one tick period, JOY_CLK=1, bit index=0, then go to SHIFT_LO.
  - SHIFT_LO: JOY_CLK=0, JOY_LOAD=1. At the tick, shift ~JOY_DATA into the shift register, then go to SHIFT_HI.
  - SHIFT_HI: JOY_CLK=1 (this rising edge advances the chain). At the tick, increment the bit index. If index == NUM_PLAYERS*BITS_PER_PLAYER-1 go to DONE, else go to SHIFT_LO.
  - DONE: lasts one clk, not tick-gated. Performs the per-player update below, pulses scan_done, then goes to IDLE.
- Bit order: the first sampled bit is player 0 bit B-1. Within a player, bits are MSB first; players follow in increasing order. This matches the existing layout, where bits 3..0 are U,D,L,R.
- Scan latency: 1 + 2*TOTAL ticks from LOAD entry, plus 1 clk for DONE.
- enable deasserted mid-scan: the current scan completes normally; the next scan is not started.
- Per-player update in DONE, with raw = that player's slice after inversion:
  - If raw is all ones (data line stuck low / no device): present=0, joystick slice forced to 0, candidate and counter cleared. changed pulses if the slice was nonzero.
  - Otherwise present=1. If raw != candidate: candidate=raw, count=1. Else count saturates at DEBOUNCE.
  - If count reaches DEBOUNCE and candidate != the current joystick slice: load the slice and pulse changed[p] in the same cycle as scan_done.
  - With DEBOUNCE=1, a new raw value updates the outputs in the same DONE cycle.
- All outputs are registered. Multiple players may pulse changed in the same cycle.

Test Plan:
- Bench configuration for all scenarios: NUM_PLAYERS=2, BITS=12, CLK_DIV=4, SCAN_GAP=2, DEBOUNCE=2.
- Reset/idle: hold Reset_n=0 for 5 clk → JOY_CLK=1, JOY_LOAD=1, joystick=0, present=0. Release with enable=0 → no JOY_LOAD low for 200 clk.
- Waveform timing: enable=1 → JOY_LOAD low for exactly 4 clk, then 24 JOY_CLK low/high pairs of 4 clk each; scan_done pulses once, 4+192+1 clk after JOY_LOAD falls.
- Decode + debounce: chain model drives P0=12'h008 (Up) and P1=12'h011 active-high → after scan 1, joystick unchanged (0). After scan 2, joystick={12'h011,12'h008}, changed=2'b11, present=2'b11.
- Glitch rejection: stable P0=12'h001, then one scan of 12'h002, then 12'h001 again → joystick P0 stays 12'h001 throughout and changed[0] never pulses.
- Absent device: JOY_DATA held 0 for P1's 12 bits → present=2'b01, P1 slice=0, and changed[1] pulses once if P1 was previously nonzero.
- Mid-scan reset: Reset_n=0 at bit 10 of a scan carrying new data → outputs return to reset values, and the next scan starts only after a full SCAN_GAP.
